// File: rtl/bcd_counter.sv
// rtl/bcd_counter.sv - single-digit free-running decimal counter with terminal-count decode
module bcd_counter #(
    parameter int unsigned MAX_COUNT   = 9,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic       clk,
    input  logic       reset,
    output logic [3:0] dout,
    output logic       tc
);

    localparam logic [3:0] MAX_C = 4'(MAX_COUNT);
    localparam logic [3:0] RST_V = 4'(RESET_VALUE);

    // Declaration initialiser gives a defined digit even if reset is never asserted.
    logic [3:0] count_q = RST_V;
    logic [3:0] count_d;

    // The >= compare folds the wrap and the recovery from illegal codes into one branch.
    always_comb begin
        count_d = count_q + 4'd1;
        if (reset) begin
            count_d = RST_V;
        end else if (count_q >= MAX_C) begin
            count_d = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign dout = count_q;
    assign tc   = (count_q == MAX_C);

endmodule

// File: tb/tb_bcd_counter.sv
// tb/tb_bcd_counter.sv - scoreboard bench for bcd_counter with a two-digit cascade
module tb_bcd_counter;

    logic       clk = 1'b1;
    logic       reset = 1'b0;
    logic       casc_reset = 1'b0;
    logic [3:0] dout, dout5, ones, tens;
    logic       tc, tc5, tc_ones, tc_tens;
    logic       en_q = 1'b0;
    logic       gclk;

    typedef struct packed {
        logic [3:0] d9;
        logic       t9;
        logic [3:0] d5;
        logic       t5;
    } exp_t;

    exp_t sb[$];
    int   m9 = 0;
    int   m5 = 3;
    int   casc = 0;
    int   checks = 0;
    int   errors = 0;

    always #50 clk = ~clk;

    bcd_counter dut (.clk(clk), .reset(reset), .dout(dout), .tc(tc));

    bcd_counter #(.MAX_COUNT(5), .RESET_VALUE(3)) dut5 (
        .clk(clk), .reset(reset), .dout(dout5), .tc(tc5)
    );

    // Tens digit advances on the edge where the ones digit wraps (latch-style clock gate).
    always @(negedge clk) en_q <= tc_ones;
    assign gclk = clk & en_q;

    bcd_counter u_ones (.clk(clk),  .reset(casc_reset), .dout(ones), .tc(tc_ones));
    bcd_counter u_tens (.clk(gclk), .reset(casc_reset), .dout(tens), .tc(tc_tens));

    function automatic int nxt(input int m, input int mx, input int rv, input bit r);
        if (r) return rv;
        return (m < mx) ? m + 1 : 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit inj, input logic [3:0] v, input bit pulse);
        exp_t e;
        @(negedge clk);
        reset = rst;
        if (inj) begin
            dut.count_q = v;
            m9 = int'(v);
        end
        m9 = nxt(m9, 9, 0, rst);
        m5 = nxt(m5, 5, 3, rst);
        e.d9 = 4'(m9);
        e.t9 = (m9 == 9);
        e.d5 = 4'(m5);
        e.t5 = (m5 == 5);
        sb.push_back(e);
        if (pulse && !rst) begin
            #10 reset = 1'b1;
            #10 reset = 1'b0;
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        casc = (casc + 1) % 100;
        check("cascade", int'(tens) * 10 + int'(ones), casc);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("dout",  int'(dout),  int'(e.d9));
            check("tc",    int'(tc),    int'(e.t9));
            check("dout5", int'(dout5), int'(e.d5));
            check("tc5",   int'(tc5),   int'(e.t5));
        end
    end

    initial begin
        #1;
        check("pwrup_dout",  int'(dout),  0);
        check("pwrup_tc",    int'(tc),    0);
        check("pwrup_dout5", int'(dout5), 3);
        check("pwrup_tc5",   int'(tc5),   0);
        check("pwrup_casc",  int'(tens) * 10 + int'(ones), 0);

        repeat (20) step(1'b0, 1'b0, 4'd0, 1'b0);
        repeat (5)  step(1'b0, 1'b0, 4'd0, 1'b0);
        repeat (3)  step(1'b1, 1'b0, 4'd0, 1'b0);
        repeat (3)  step(1'b0, 1'b0, 4'd0, 1'b0);
        repeat (2)  step(1'b0, 1'b0, 4'd0, 1'b1);
        step(1'b0, 1'b1, 4'd12, 1'b0);
        repeat (4)  step(1'b0, 1'b0, 4'd0, 1'b0);
        step(1'b0, 1'b1, 4'd15, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b0);

        for (int i = 0; i < 160; i++) begin
            logic [3:0] v;
            v = 4'($urandom_range(10, 15));
            step($urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0, v,
                 $urandom_range(0, 9) == 0);
        end

        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("sb_drain", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_counter.md
Name: bcd_counter

Overview:
- Single-digit, free-running, synchronous decimal (BCD) counter: 0,1,…,9,0,…
- Advances once per rising clock edge. Leaf block used as a digit stage, e.g. for display or timing chains.
- Optional terminal-count output lets several instances be cascaded into multi-digit counters.

Parameters:
- MAX_COUNT, 9, last value before wrap; legal range 1..9; 9 gives standard BCD.
- RESET_VALUE, 0, value loaded by reset and at power-up; must be ≤ MAX_COUNT.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- dout  output  4  current BCD digit, driven directly from a register (no combinational path from inputs).
- tc  output  1  terminal count: high while dout == MAX_COUNT. Combinational decode of the dout register only. May be left unconnected.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high. No asynchronous reset path; reset is sampled only on clk rising edge.
- Power-up/initial register value = RESET_VALUE (0). This makes dout defined and counting valid even if reset is never asserted.
- Each clk rising edge, in priority order:
  - reset == 1 → dout <= RESET_VALUE (0).
  - else if dout == MAX_COUNT (9) → dout <= 0 (wrap).
  - else if dout > MAX_COUNT (illegal code 10..15, e.g. after upset) → dout <= 0. No lock-up in any state.
  - else → dout <= dout + 1.
- Latency: a reset sampled at edge N gives dout = 0 after edge N. Counting resumes at the first edge where reset is low: 0→1.
- Reset held for several cycles → dout stays 0; no counting while reset is high.
- Reset rising coincident with a clk rising edge (same timestep, testbench-style) → treated as sampled high at that edge; dout becomes 0.
- Reset mid-count (any value 1..9) → 0 on that edge; no partial or other intermediate values.
- tc:
  - = 1 exactly when dout == MAX_COUNT, else 0.
  - Under reset, tc follows dout (0 after reset unless MAX_COUNT == 0, which is disallowed).
- dout changes only on clk rising edges; no glitches from reset deassertion between edges.
- Width rule: dout is 4 bits regardless of MAX_COUNT. Upper unused codes are never produced in normal operation.

Test Plan:
- Power-up, reset=0, 10 clk edges (50 ns half-period) → dout sequence 1,2,…,9,0 after edges 1..10; dout=0 after edge 10.
- Continue from 0 with 10 more edges, reset=0 → repeats 1..9,0; tc=1 only while dout==9; tc=0 during all other cycles.
- Count to 5, then raise reset in the same timestep as a clk rise → dout=0 after that edge; hold reset 3 edges → stays 0; release → next edge dout=1.
- Reset asserted and deasserted between clk edges without a rising edge in between → dout unchanged.
- Force dout register to 12 (illegal), reset=0, one edge → dout=0, then normal counting 1,2,….
- Cascade check: two instances, second clocked with enable derived from first tc (wrapper) over 100 edges → combined value 00..99 then 00.
